// File: rtl/df_pkg.sv
`default_nettype none
// df_pkg -- arbiter state encoding and default byte width shared by the read-arbiter files.
// Revision 1.0
package df_pkg;

  localparam int DF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_select.sv
`default_nettype none
// rr_select -- combinational round-robin next-grant selection for df_read_arbiter.
// Revision 1.0
module rr_select
  import df_pkg::*;
(
  input  logic [1:0] state,
  input  logic       last,
  input  logic       empty0,
  input  logic       empty1,
  input  logic       switch_now,
  output logic [1:0] next_state
);

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        // With both ports ready, the one not served last goes first.
        if (!empty0 && !empty1) begin
          next_state = last ? GRANT0 : GRANT1;
        end else if (!empty0) begin
          next_state = GRANT0;
        end else if (!empty1) begin
          next_state = GRANT1;
        end
      end
      GRANT0: begin
        if (empty0) begin
          next_state = empty1 ? IDLE : GRANT1;
        end else if (!empty1 && switch_now) begin
          next_state = GRANT1;
        end
      end
      GRANT1: begin
        if (empty1) begin
          next_state = empty0 ? IDLE : GRANT0;
        end else if (!empty0 && switch_now) begin
          next_state = GRANT0;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/df_read_arbiter.sv
`default_nettype none
// df_read_arbiter -- round-robin pop arbiter for two receive FIFOs, merging bytes onto one tagged stream.
// Revision 1.0. Define ARB_BURST_EN to grant up to BURST consecutive reads per port.
module df_read_arbiter
  import df_pkg::*;
#(
  parameter int DATA_W = DF_DATA_W,
  parameter int BURST  = 4
) (
  input  logic              clk8f,
  input  logic              reset,
  input  logic              enable,
  input  logic              pause,
  input  logic              empty0,
  input  logic              empty1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              read0,
  output logic              read1,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              src_id
);

  arb_state_t state;
  arb_state_t state_nxt;
  logic [1:0] sel_next;
  logic       last;
  logic       go;
  logic       switch_now;
  logic       pending;
  logic       pend_src;

  assign go    = enable & ~pause;
  assign read0 = (state == GRANT0) & ~empty0 & go;
  assign read1 = (state == GRANT1) & ~empty1 & go;

  rr_select u_rr_select (
    .state      (state),
    .last       (last),
    .empty0     (empty0),
    .empty1     (empty1),
    .switch_now (switch_now),
    .next_state (sel_next)
  );

  // Arbitration is frozen while paused or disabled.
  always_comb begin
    state_nxt = state;
    if (go) begin
      state_nxt = arb_state_t'(sel_next);
    end
  end

  always_ff @(posedge clk8f or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (read0) begin
        last <= 1'b0;
      end else if (read1) begin
        last <= 1'b1;
      end
    end
  end

`ifdef ARB_BURST_EN
  localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);

  logic [CNT_W-1:0] burst_cnt;

  assign switch_now = (burst_cnt == CNT_LAST);

  // Saturates at the limit so a port that becomes ready later is served at once.
  always_ff @(posedge clk8f or negedge reset) begin
    if (!reset) begin
      burst_cnt <= '0;
    end else if (state_nxt != state) begin
      burst_cnt <= '0;
    end else if ((read0 | read1) && !switch_now) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end
`else
  // Without the counter every read hands over; BURST only needs to be a legal value.
  assign switch_now = (BURST >= 1);
`endif

  // Popped data appears one cycle after the strobe, so capture one cycle later.
  always_ff @(posedge clk8f or negedge reset) begin
    if (!reset) begin
      pending   <= 1'b0;
      pend_src  <= 1'b0;
      data_out  <= '0;
      valid_out <= 1'b0;
      src_id    <= 1'b0;
    end else begin
      pending   <= read0 | read1;
      pend_src  <= read1;
      valid_out <= pending;
      if (pending) begin
        data_out <= pend_src ? data1 : data0;
        src_id   <= pend_src;
      end
    end
  end

endmodule
`default_nettype wire
